memory_access_unit: RTL and testbench

Sits between the processor's load/store stage and one port of the dual-port block memory. Turns byte/halfword/word requests at arbitrary byte addresses into word-granular memory accesses with byte enables. Splits word-boundary-crossing accesses into two consecutive word accesses. Returns little-endian, sign- or zero-extended load data over a one-pulse response.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/byte_lane_shifter.sv | 57 +++++
 rtl/memory_access_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit: access sizes, FSM states
// and the lane-count / word-crossing helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        WAIT = 2'd3
    } mau_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        logic [2:0] n;
        case (mem_size_t'(size))
            MEM_SIZE_BYTE: n = 3'd1;
            MEM_SIZE_HALF: n = 3'd2;
            default:       n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic is_crossing(input logic [1:0] offset, input logic [1:0] size);
        return ({1'b0, offset} + size_nbytes(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/byte_lane_shifter.sv
// Combinational lane steering: store data/mask placement across a {hi,lo} word
// pair, and load byte extraction with sign/zero extension.
import mem_pkg::*;

module byte_lane_shifter (
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_offset_i,
    output logic [63:0] st_lanes_o,
    output logic [7:0]  st_mask_o,
    input  logic [31:0] ld_lo_i,
    input  logic [31:0] ld_hi_i,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_offset_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  base_mask_s;
    logic [31:0] ld_word_s;

    // Store side: shift data and byte mask up by the byte offset.
    always_comb begin
        base_mask_s = 8'h0F;
        case (mem_size_t'(st_size_i))
            MEM_SIZE_BYTE: base_mask_s = 8'h01;
            MEM_SIZE_HALF: base_mask_s = 8'h03;
            default:       base_mask_s = 8'h0F;
        endcase
        st_lanes_o = {32'd0, st_data_i} << {st_offset_i, 3'b000};
        st_mask_o  = base_mask_s << st_offset_i;
    end

    // Load side: bring the addressed byte down to lane 0, then extend.
    always_comb begin
        ld_word_s = 32'({ld_hi_i, ld_lo_i} >> {ld_offset_i, 3'b000});
        ld_data_o = ld_word_s;
        case (mem_size_t'(ld_size_i))
            MEM_SIZE_BYTE: begin
                if (ld_unsigned_i) begin
                    ld_data_o = {24'd0, ld_word_s[7:0]};
                end else begin
                    ld_data_o = {{24{ld_word_s[7]}}, ld_word_s[7:0]};
                end
            end
            MEM_SIZE_HALF: begin
                if (ld_unsigned_i) begin
                    ld_data_o = {16'd0, ld_word_s[15:0]};
                end else begin
                    ld_data_o = {{16{ld_word_s[15]}}, ld_word_s[15:0]};
                end
            end
            default: ld_data_o = ld_word_s;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Load/store front end for one block-memory port: splits unaligned accesses
// into lo/hi word accesses with byte enables and returns extended load data.
import mem_pkg::*;

module memory_access_unit #(
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_BITS-1:0] req_address,
    input  logic [31:0]          req_wr_data,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rd_en,
    output logic [31:0]          mem_wr_data,
    output logic [3:0]           mem_wr_en,
    input  logic [31:0]          mem_rd_data
);

    mau_state_t state_q, state_d;

    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [1:0]           offset_q, offset_d;
    logic                 crossing_q, crossing_d;
    logic [ADDR_BITS-1:0] hi_addr_q, hi_addr_d;
    logic [31:0]          hi_lanes_q, hi_lanes_d;
    logic [3:0]           hi_mask_q, hi_mask_d;
    logic [31:0]          lo_data_q, lo_data_d;
    logic [ADDR_BITS-1:0] mem_address_q, mem_address_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic [31:0]          mem_wr_data_q, mem_wr_data_d;
    logic [3:0]           mem_wr_en_q, mem_wr_en_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;

    logic [ADDR_BITS-1:0] lo_addr_s;
    logic [63:0]          st_lanes_s;
    logic [7:0]           st_mask_s;
    logic [31:0]          ld_lo_s, ld_hi_s, ld_data_s;

    assign lo_addr_s = {req_address[ADDR_BITS-1:2], 2'b00};
    // The final read word is the hi half for crossing loads, the only half otherwise.
    assign ld_lo_s   = crossing_q ? lo_data_q : mem_rd_data;
    assign ld_hi_s   = crossing_q ? mem_rd_data : 32'd0;

    byte_lane_shifter u_shifter (
        .st_data_i     (req_wr_data),
        .st_size_i     (req_size),
        .st_offset_i   (req_address[1:0]),
        .st_lanes_o    (st_lanes_s),
        .st_mask_o     (st_mask_s),
        .ld_lo_i       (ld_lo_s),
        .ld_hi_i       (ld_hi_s),
        .ld_size_i     (size_q),
        .ld_offset_i   (offset_q),
        .ld_unsigned_i (unsigned_q),
        .ld_data_o     (ld_data_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = LO;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                if (crossing_q) begin
                    state_d = HI;
                end else if (write_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            HI: begin
                if (write_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: strobes are prepared one cycle ahead so they are registered.
    always_comb begin
        write_d       = write_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        offset_d      = offset_q;
        crossing_d    = crossing_q;
        hi_addr_d     = hi_addr_q;
        hi_lanes_d    = hi_lanes_q;
        hi_mask_d     = hi_mask_q;
        lo_data_d     = lo_data_q;
        mem_address_d = mem_address_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_rd_en_d   = 1'b0;
        mem_wr_en_d   = 4'b0000;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d       = req_write;
                    size_d        = req_size;
                    unsigned_d    = req_unsigned;
                    offset_d      = req_address[1:0];
                    crossing_d    = is_crossing(req_address[1:0], req_size);
                    hi_addr_d     = lo_addr_s + ADDR_BITS'(BYTES_PER_WORD);
                    hi_lanes_d    = st_lanes_s[63:32];
                    hi_mask_d     = st_mask_s[7:4];
                    mem_address_d = lo_addr_s;
                    if (req_write) begin
                        mem_wr_en_d   = st_mask_s[3:0];
                        mem_wr_data_d = st_lanes_s[31:0];
                    end else begin
                        mem_rd_en_d   = 1'b1;
                    end
                end else begin
                    mem_rd_en_d = 1'b0;
                end
            end
            LO: begin
                if (crossing_q) begin
                    mem_address_d = hi_addr_q;
                    if (write_q) begin
                        mem_wr_en_d   = hi_mask_q;
                        mem_wr_data_d = hi_lanes_q;
                    end else begin
                        mem_rd_en_d   = 1'b1;
                    end
                end else if (write_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'd0;
                end else begin
                    rsp_valid_d = 1'b0;
                end
            end
            HI: begin
                if (write_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 32'd0;
                end else begin
                    lo_data_d   = mem_rd_data;
                end
            end
            WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = ld_data_s;
            end
            default: rsp_valid_d = 1'b0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q       <= 1'b0;
            size_q        <= 2'd0;
            unsigned_q    <= 1'b0;
            offset_q      <= 2'd0;
            crossing_q    <= 1'b0;
            hi_addr_q     <= '0;
            hi_lanes_q    <= 32'd0;
            hi_mask_q     <= 4'b0000;
            lo_data_q     <= 32'd0;
            mem_address_q <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_data_q <= 32'd0;
            mem_wr_en_q   <= 4'b0000;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
        end else begin
            write_q       <= write_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            offset_q      <= offset_d;
            crossing_q    <= crossing_d;
            hi_addr_q     <= hi_addr_d;
            hi_lanes_q    <= hi_lanes_d;
            hi_mask_q     <= hi_mask_d;
            lo_data_q     <= lo_data_d;
            mem_address_q <= mem_address_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_wr_en_q   <= mem_wr_en_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    // Strobes are masked while reset is held so an interrupted hi write never reaches memory.
    assign req_ready   = (state_q == IDLE) && !reset;
    assign mem_rd_en   = mem_rd_en_q & ~reset;
    assign mem_wr_en   = mem_wr_en_q & {4{~reset}};
    assign mem_address = mem_address_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a small behavioural block memory.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [6:0]  req_address;
    logic [31:0] req_wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [6:0]  mem_address;
    logic        mem_rd_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_en;
    logic [31:0] mem_rd_data;

    logic [31:0] mem [32];
    logic        preload;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] c_addr [1:6];
    logic [31:0] c_wdata [1:6];
    logic [3:0]  c_wr [1:6];
    logic        c_rd [1:6];
    int          rd_cnt, wr_cnt, rsp_cnt, rsp_lat;
    logic [31:0] rsp_d;

    memory_access_unit #(.ADDR_BITS(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_address  (req_address),
        .req_wr_data  (req_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_address  (mem_address),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_data  (mem_rd_data)
    );

    always #5 clk = ~clk;

    // Block memory: byte-enabled writes, registered reads.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            mem[0]  <= 32'h44332211;
            mem[1]  <= 32'h88776655;
            mem[31] <= 32'hDDCCBBAA;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wr_en[b]) mem[mem_address[6:2]][8*b +: 8] <= mem_wr_data[8*b +: 8];
        end
        if (mem_rd_en) mem_rd_data <= mem[mem_address[6:2]];
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one request, then record six cycles of memory-side and response activity.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [6:0] a, input logic [31:0] d);
        req_write = w; req_size = sz; req_unsigned = uns; req_address = a; req_wr_data = d;
        req_valid = 1'b1;
        @(negedge clk);
        check_vec("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0; rsp_lat = 0; rsp_d = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            c_rd[k] = mem_rd_en; c_wr[k] = mem_wr_en;
            c_addr[k] = 32'(mem_address); c_wdata[k] = mem_wr_data;
            if (mem_rd_en) rd_cnt++;
            if (mem_wr_en != 4'b0000) wr_cnt++;
            if (rsp_valid) begin rsp_cnt++; rsp_lat = k; rsp_d = rsp_data; end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_rsp(input string tag, input int lat, input logic [31:0] data);
        check_vec({tag, "_rspcnt"}, 32'(rsp_cnt), 32'd1);
        check_vec({tag, "_lat"}, 32'(rsp_lat), 32'(lat));
        check_vec({tag, "_data"}, rsp_d, data);
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_address = 7'd0; req_wr_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("rst_ready", 32'(req_ready), 32'd0);
        check_vec("rst_rspv", 32'(rsp_valid), 32'd0);
        check_vec("rst_rspd", rsp_data, 32'd0);
        check_vec("rst_addr", 32'(mem_address), 32'd0);
        check_vec("rst_rden", 32'(mem_rd_en), 32'd0);
        check_vec("rst_wren", 32'(mem_wr_en), 32'd0);
        check_vec("rst_wdata", mem_wr_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; preload = 1'b0;
        @(negedge clk);
        check_vec("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Aligned word load
        run_req(1'b0, 2'd2, 1'b0, 7'd0, 32'd0);
        check_vec("lw0_rd1", 32'(c_rd[1]), 32'd1);
        check_vec("lw0_addr1", c_addr[1], 32'd0);
        check_vec("lw0_rdcnt", 32'(rd_cnt), 32'd1);
        check_vec("lw0_wrcnt", 32'(wr_cnt), 32'd0);
        check_rsp("lw0", 3, 32'h44332211);

        run_req(1'b0, 2'd0, 1'b0, 7'd7, 32'd0);
        check_rsp("lb7s", 3, 32'hFFFFFF88);
        run_req(1'b0, 2'd0, 1'b1, 7'd7, 32'd0);
        check_rsp("lb7u", 3, 32'h00000088);
        run_req(1'b0, 2'd1, 1'b0, 7'd6, 32'd0);
        check_rsp("lh6s", 3, 32'hFFFF8877);

        // Crossing word load
        run_req(1'b0, 2'd2, 1'b0, 7'd2, 32'd0);
        check_vec("lw2_addr1", c_addr[1], 32'd0);
        check_vec("lw2_addr2", c_addr[2], 32'd4);
        check_vec("lw2_rdcnt", 32'(rd_cnt), 32'd2);
        check_rsp("lw2", 4, 32'h66554433);

        // Crossing halfword store
        run_req(1'b1, 2'd1, 1'b0, 7'd3, 32'h0000BEEF);
        check_vec("sh3_addr1", c_addr[1], 32'd0);
        check_vec("sh3_wr1", 32'(c_wr[1]), 32'h8);
        check_vec("sh3_b3", 32'(c_wdata[1][31:24]), 32'hEF);
        check_vec("sh3_addr2", c_addr[2], 32'd4);
        check_vec("sh3_wr2", 32'(c_wr[2]), 32'h1);
        check_vec("sh3_b0", 32'(c_wdata[2][7:0]), 32'hBE);
        check_vec("sh3_rdcnt", 32'(rd_cnt), 32'd0);
        check_rsp("sh3", 3, 32'd0);
        run_req(1'b0, 2'd2, 1'b0, 7'd0, 32'd0);
        check_rsp("rb0", 3, 32'hEF332211);
        run_req(1'b0, 2'd3, 1'b0, 7'd4, 32'd0);
        check_rsp("rb4_sz3", 3, 32'h887766BE);

        // Wrap at top of memory
        run_req(1'b0, 2'd2, 1'b0, 7'd126, 32'd0);
        check_vec("lw126_addr1", c_addr[1], 32'd124);
        check_vec("lw126_addr2", c_addr[2], 32'd0);
        check_rsp("lw126", 4, 32'h2211DDCC);

        // Aligned byte store
        run_req(1'b1, 2'd0, 1'b0, 7'd9, 32'h0000005A);
        check_vec("sb9_addr1", c_addr[1], 32'd8);
        check_vec("sb9_wr1", 32'(c_wr[1]), 32'h2);
        check_vec("sb9_b1", 32'(c_wdata[1][15:8]), 32'h5A);
        check_vec("sb9_wrcnt", 32'(wr_cnt), 32'd1);
        check_rsp("sb9", 2, 32'd0);

        // Back-to-back: second request offered in the first's rsp cycle
        req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_address = 7'd8;
        req_wr_data = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        req_write = 1'b0; req_address = 7'd8; req_valid = 1'b1;
        @(negedge clk);
        check_vec("b2b_rspv", 32'(rsp_valid), 32'd1);
        check_vec("b2b_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("b2b_ld_rspv", 32'(rsp_valid), 32'd1);
        check_vec("b2b_ld_data", rsp_data, 32'h12345678);
        @(posedge clk); #1;

        // Reset during HI of a crossing store
        req_write = 1'b1; req_size = 2'd1; req_address = 7'h13; req_wr_data = 32'h00005566;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_vec("rst_lo_wren", 32'(mem_wr_en), 32'h8);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_vec("rst_hi_wren", 32'(mem_wr_en), 32'h0);
        check_vec("rst_hi_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) check_vec("rst_after_ready", 32'(req_ready), 32'd1);
            if (rsp_valid) rsp_cnt++;
        end
        check_vec("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        @(posedge clk); #1;
        run_req(1'b0, 2'd2, 1'b0, 7'h10, 32'd0);
        check_rsp("rst_lo_kept", 3, 32'h66000000);
        run_req(1'b0, 2'd2, 1'b0, 7'h14, 32'd0);
        check_rsp("rst_hi_dropped", 3, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
